// File: rtl/pid_seq_pkg.sv
// Shared types and widths for the PID loop sequencer.
// Fixed-point values are signed Q16.16; sensor samples are 12-bit signed.
package pid_seq_pkg;
  localparam int FRAC_BITS = 16;
  localparam int Q_W       = 32;
  localparam int SENSOR_W  = 12;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_TICK,
    S_ADC_REQ,
    S_ADC_WAIT,
    S_PID_RUN,
    S_CAPTURE,
    S_FAULT
  } state_e;

  function automatic logic signed [Q_W-1:0] q_clamp(
    input logic signed [Q_W-1:0] v,
    input logic signed [Q_W-1:0] lo,
    input logic signed [Q_W-1:0] hi
  );
    if (v < lo)      return lo;
    else if (v > hi) return hi;
    else             return v;
  endfunction
endpackage

// File: rtl/sample_tick_gen.sv
// Sample-period divider: one-cycle tick every SAMPLE_DIV cycles while enabled.
module sample_tick_gen #(
  parameter int SAMPLE_DIV = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);
  localparam int              CW   = $clog2(SAMPLE_DIV);
  localparam logic [CW-1:0]   LAST = CW'(SAMPLE_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = '0;
    if (enable) cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tick = enable && (cnt_q == LAST);
endmodule

// File: rtl/pid_loop_sequencer.sv
// Runs one ADC -> PID -> clamp/publish cycle per sample tick, with ADC timeout
// fault handling and a saturating count of ticks lost while a sample was busy.
module pid_loop_sequencer
  import pid_seq_pkg::*;
#(
  parameter int                     SAMPLE_DIV  = 50000,
  parameter int                     PID_CYCLES  = 2,
  parameter int                     ADC_TIMEOUT = 1023,
  parameter logic signed [Q_W-1:0]  OUT_MIN     = 32'sh0000_0000,
  parameter logic signed [Q_W-1:0]  OUT_MAX     = 32'sh00FF_0000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [Q_W-1:0]             setpoint_in,
  input  logic                       setpoint_load,
  input  logic                       fault_clr,
  output logic                       adc_start,
  input  logic                       adc_valid,
  input  logic [SENSOR_W-1:0]        adc_data,
  output logic [SENSOR_W-1:0]        pid_sensor,
  output logic [Q_W-1:0]             pid_setpoint,
  output logic                       pid_ce,
  input  logic signed [Q_W-1:0]      pid_out,
  output logic [Q_W-1:0]             ctrl_out,
  output logic                       ctrl_valid,
  output logic                       fault,
  output logic [7:0]                 overrun_cnt
);
  localparam int            TW      = $clog2(ADC_TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(ADC_TIMEOUT - 1);
  localparam logic [3:0]    PC_LAST = 4'(PID_CYCLES - 1);

  logic tick;

  sample_tick_gen #(.SAMPLE_DIV(SAMPLE_DIV)) u_tick (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .tick   (tick)
  );

  state_e                state_q, state_d;
  logic [TW-1:0]         to_cnt_q, to_cnt_d;
  logic [3:0]            pcnt_q, pcnt_d;
  logic [Q_W-1:0]        pend_q, pend_d;
  logic [SENSOR_W-1:0]   sens_q, sens_d;
  logic [Q_W-1:0]        sp_q, sp_d;
  logic [Q_W-1:0]        ctrl_q, ctrl_d;
  logic [7:0]            ovr_q, ovr_d;
  logic                  adc_start_q, adc_start_d;
  logic                  pid_ce_q, pid_ce_d;
  logic                  ctrl_valid_q, ctrl_valid_d;
  logic                  fault_q, fault_d;

  always_comb begin
    state_d  = state_q;
    to_cnt_d = to_cnt_q;
    pcnt_d   = pcnt_q;
    pend_d   = setpoint_load ? setpoint_in : pend_q;
    sens_d   = sens_q;
    sp_d     = sp_q;
    ctrl_d   = ctrl_q;
    ovr_d    = ovr_q;

    if (tick && state_q != S_IDLE && state_q != S_WAIT_TICK && ovr_q != 8'hFF)
      ovr_d = ovr_q + 8'd1;

    // Dropping enable aborts the sample without touching the data registers.
    if (!enable && state_q != S_FAULT) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE:      if (!fault_q) state_d = S_WAIT_TICK;
        S_WAIT_TICK: if (tick) state_d = S_ADC_REQ;
        S_ADC_REQ: begin
          sp_d     = pend_q;
          to_cnt_d = '0;
          state_d  = S_ADC_WAIT;
        end
        S_ADC_WAIT: begin
          if (adc_valid) begin
            sens_d  = adc_data;
            pcnt_d  = '0;
            state_d = S_PID_RUN;
          end else if (to_cnt_q == TO_LAST) begin
            state_d = S_FAULT;
          end else begin
            to_cnt_d = to_cnt_q + 1'b1;
          end
        end
        S_PID_RUN: begin
          if (pcnt_q == PC_LAST) state_d = S_CAPTURE;
          else                   pcnt_d  = pcnt_q + 4'd1;
        end
        S_CAPTURE:   state_d = S_WAIT_TICK;
        S_FAULT:     if (fault_clr) state_d = S_IDLE;
        default:     state_d = S_IDLE;
      endcase
    end

    // pid_out is sampled on the final enabled PID edge so ctrl_out lands with ctrl_valid.
    if (state_d == S_CAPTURE) ctrl_d = q_clamp(pid_out, OUT_MIN, OUT_MAX);

    adc_start_d  = (state_d == S_ADC_REQ);
    pid_ce_d     = (state_d == S_PID_RUN);
    ctrl_valid_d = (state_d == S_CAPTURE);
    fault_d      = (state_d == S_FAULT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      to_cnt_q     <= '0;
      pcnt_q       <= '0;
      pend_q       <= '0;
      sens_q       <= '0;
      sp_q         <= '0;
      ctrl_q       <= '0;
      ovr_q        <= '0;
      adc_start_q  <= 1'b0;
      pid_ce_q     <= 1'b0;
      ctrl_valid_q <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      to_cnt_q     <= to_cnt_d;
      pcnt_q       <= pcnt_d;
      pend_q       <= pend_d;
      sens_q       <= sens_d;
      sp_q         <= sp_d;
      ctrl_q       <= ctrl_d;
      ovr_q        <= ovr_d;
      adc_start_q  <= adc_start_d;
      pid_ce_q     <= pid_ce_d;
      ctrl_valid_q <= ctrl_valid_d;
      fault_q      <= fault_d;
    end
  end

  assign adc_start    = adc_start_q;
  assign pid_sensor   = sens_q;
  assign pid_setpoint = sp_q;
  assign pid_ce       = pid_ce_q;
  assign ctrl_out     = ctrl_q;
  assign ctrl_valid   = ctrl_valid_q;
  assign fault        = fault_q;
  assign overrun_cnt  = ovr_q;
endmodule

// File: tb/tb_pid_loop_sequencer.sv
// Directed + randomized bench for pid_loop_sequencer with an ADC responder,
// an event monitor and an arithmetic reference for timing and clamping.
module tb_pid_loop_sequencer;
  import pid_seq_pkg::*;

  logic        clk = 1'b0;
  logic        reset, enable, setpoint_load, fault_clr, adc_valid;
  logic [31:0] setpoint_in, pid_out;
  logic [11:0] adc_data;
  logic        adc_start, pid_ce, ctrl_valid, fault;
  logic [11:0] pid_sensor;
  logic [31:0] pid_setpoint, ctrl_out;
  logic [7:0]  overrun_cnt;

  pid_loop_sequencer #(
    .SAMPLE_DIV(100), .PID_CYCLES(2), .ADC_TIMEOUT(20)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .setpoint_in(setpoint_in), .setpoint_load(setpoint_load), .fault_clr(fault_clr),
    .adc_start(adc_start), .adc_valid(adc_valid), .adc_data(adc_data),
    .pid_sensor(pid_sensor), .pid_setpoint(pid_setpoint), .pid_ce(pid_ce),
    .pid_out(pid_out), .ctrl_out(ctrl_out), .ctrl_valid(ctrl_valid),
    .fault(fault), .overrun_cnt(overrun_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  int exp_ovr = 0;
  logic [31:0] exp_pend = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] clamp(input logic [31:0] v);
    int s;
    s = int'(v);
    if (s < 0) return 32'h0;
    if (s > 32'sh00FF_0000) return 32'h00FF_0000;
    return v;
  endfunction

  // ADC responder: answers adc_dly cycles after adc_start (0 = never answers).
  int adc_dly = 3, adc_cd = -1;
  logic [11:0] adc_val = '0;
  always @(negedge clk) begin
    adc_valid = 1'b0;
    if (!reset) adc_cd = -1;
    else begin
      if (adc_cd > 0) begin
        adc_cd--;
        if (adc_cd == 0) begin adc_valid = 1'b1; adc_data = adc_val; adc_cd = -1; end
      end
      if (adc_start && adc_dly > 0) adc_cd = adc_dly;
    end
  end

  // Event monitor, sampled shortly after each active edge.
  int cyc = 0, n_start = 0, t_start = 0, t_start_prev = 0, n_ce_smp = 0;
  int t_ce_first = 0, t_ce_last = 0, n_cv = 0, t_cv = 0, t_fault = 0;
  logic [31:0] cv_val = '0;
  logic prev_fault = 1'b0;
  always @(posedge clk) begin
    #3;
    cyc++;
    if (adc_start) begin n_start++; t_start_prev = t_start; t_start = cyc; n_ce_smp = 0; end
    if (pid_ce) begin
      if (n_ce_smp == 0) t_ce_first = cyc;
      n_ce_smp++;
      t_ce_last = cyc;
    end
    if (ctrl_valid) begin n_cv++; t_cv = cyc; cv_val = ctrl_out; end
    if (fault && !prev_fault) t_fault = cyc;
    prev_fault = fault;
  end

  task automatic chk_zero(input string tag);
    chk({tag, " adc_start"}, adc_start, 0);
    chk({tag, " pid_sensor"}, pid_sensor, 0);
    chk({tag, " pid_setpoint"}, pid_setpoint, 0);
    chk({tag, " pid_ce"}, pid_ce, 0);
    chk({tag, " ctrl_out"}, ctrl_out, 0);
    chk({tag, " ctrl_valid"}, ctrl_valid, 0);
    chk({tag, " fault"}, fault, 0);
    chk({tag, " overrun_cnt"}, overrun_cnt, 0);
  endtask

  task automatic load_sp(input logic [31:0] v);
    @(negedge clk); setpoint_in = v; setpoint_load = 1'b1;
    @(negedge clk); setpoint_load = 1'b0;
    exp_pend = v;
  endtask

  task automatic wait_start(input int s0);
    for (int i = 0; i < 250 && n_start == s0; i++) @(negedge clk);
    chk("adc_start seen", n_start - s0, 1);
  endtask

  task automatic run_sample(input int d, input logic [31:0] po, input logic [11:0] ad,
                            input bit contig, input bit ld, input logic [31:0] ld_val);
    int s0, c0;
    logic [31:0] sp_exp;
    bit done;
    adc_dly = d; adc_val = ad; pid_out = po;
    s0 = n_start; c0 = n_cv; sp_exp = exp_pend; done = 1'b0;
    wait_start(s0);
    if (contig) chk("sample period", t_start - t_start_prev, 100);
    for (int i = 0; i < 60 && n_cv == c0; i++) begin
      @(negedge clk);
      setpoint_load = 1'b0;
      if (ld && !done && pid_ce) begin
        setpoint_in = ld_val; setpoint_load = 1'b1; exp_pend = ld_val; done = 1'b1;
      end
    end
    setpoint_load = 1'b0;
    chk("ctrl_valid seen", n_cv - c0, 1);
    chk("adc_valid to pid_ce", t_ce_first - t_start, d + 1);
    chk("pid_ce cycles", n_ce_smp, 2);
    chk("last pid_ce to ctrl_valid", t_cv - t_ce_last, 1);
    chk("ctrl_out", cv_val, clamp(po));
    chk("pid_sensor", pid_sensor, ad);
    chk("pid_setpoint", pid_setpoint, sp_exp);
    @(negedge clk);
    chk("ctrl_valid single", n_cv - c0, 1);
    chk("ctrl_out held", ctrl_out, clamp(po));
    chk("overrun_cnt", overrun_cnt, exp_ovr);
  endtask

  initial begin
    int s0, c0;
    logic [31:0] co0, sp0, po;
    reset = 1'b0; enable = 1'b0; setpoint_load = 1'b0; fault_clr = 1'b0;
    setpoint_in = '0; pid_out = '0; adc_data = '0;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    reset = 1'b1;

    // Nominal sampling and saturation
    load_sp(32'(2000) << FRAC_BITS);
    enable = 1'b1;
    run_sample(3, 32'h0010_0000, 12'd1000, 0, 0, '0);
    run_sample(3, 32'h0010_0000, 12'd1000, 1, 0, '0);
    run_sample(3, 32'h0200_0000, 12'd1000, 1, 0, '0);
    run_sample(3, 32'hFFFF_0000, 12'd1000, 1, 0, '0);

    // Setpoint shadowing: load during PID_RUN takes effect next sample
    run_sample(3, 32'h0008_0000, 12'd1000, 1, 1, 32'(500) << FRAC_BITS);
    run_sample(3, 32'h0008_0000, 12'd1000, 1, 0, '0);
    chk("shadowed setpoint", pid_setpoint, 32'h01F4_0000);

    // Randomized samples including clamp boundaries
    for (int k = 0; k < 6; k++) begin
      if ($urandom_range(1) == 1) load_sp($urandom);
      case ($urandom_range(3))
        0:       po = $urandom;
        1:       po = $urandom_range(0, 32'h00FF_0000);
        2:       po = 32'h00FF_0000 - 32'd1 + 32'($urandom_range(0, 2));
        default: po = 32'($urandom_range(0, 2)) - 32'd1;
      endcase
      run_sample($urandom_range(1, 10), po, 12'($urandom), 1, 0, '0);
    end

    // ADC timeout -> fault; a tick while faulted is dropped
    adc_dly = 0; s0 = n_start; c0 = n_cv; co0 = ctrl_out;
    wait_start(s0);
    for (int i = 0; i < 60 && !fault; i++) @(negedge clk);
    chk("fault latency", t_fault - t_start, 21);
    chk("fault set", fault, 1);
    chk("no pid_ce on timeout", n_ce_smp, 0);
    chk("ctrl_out held in fault", ctrl_out, co0);
    repeat (110) @(negedge clk);
    exp_ovr = 1;
    chk("overrun after dropped tick", overrun_cnt, 1);
    chk("no sampling in fault", n_start - s0, 1);
    chk("no ctrl_valid in fault", n_cv - c0, 0);
    chk("fault sticky", fault, 1);
    fault_clr = 1'b1;
    @(negedge clk); fault_clr = 1'b0;
    chk("fault cleared", fault, 0);
    run_sample($urandom_range(1, 10), 32'h0040_0000, 12'($urandom), 0, 0, '0);

    // Abort by dropping enable during PID_RUN
    adc_dly = 3; adc_val = 12'($urandom); pid_out = 32'h0077_0000;
    s0 = n_start; c0 = n_cv;
    wait_start(s0);
    for (int i = 0; i < 20 && !pid_ce; i++) @(negedge clk);
    enable = 1'b0; co0 = ctrl_out; sp0 = pid_setpoint;
    @(negedge clk);
    chk("abort pid_ce", pid_ce, 0);
    chk("abort adc_start", adc_start, 0);
    repeat (150) @(negedge clk);
    chk("abort pid_ce count", n_ce_smp, 1);
    chk("abort no ctrl_valid", n_cv - c0, 0);
    chk("abort stays idle", n_start - s0, 1);
    chk("abort ctrl_out held", ctrl_out, co0);
    chk("abort setpoint held", pid_setpoint, sp0);
    chk("abort sensor held", pid_sensor, adc_val);

    // Asynchronous reset in the middle of ADC_WAIT
    enable = 1'b1; adc_dly = 0; s0 = n_start;
    wait_start(s0);
    repeat (5) @(negedge clk);
    #2 reset = 1'b0;
    #1 chk_zero("async reset");
    @(negedge clk); reset = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
